led_sequencer: RTL and testbench

Avalon-MM controller that drives the 8-bit LED PIO of the anemometer SOPC, so LED animations and wind-speed bargraphs run without per-step CPU writes. The CPU configures it through a small slave port: pattern table, step period, mode and run control. The block then issues timed single-cycle writes on a master port wired to the LED PIO's s1 slave (address 0, data in bits 7:0).

---
 rtl/led_sequencer.sv | 154 +++++++++++++++
 tb/tb_led_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// Avalon-MM LED sequencer: plays a pattern table or a wind-speed bargraph
// onto the LED PIO through timed single-cycle master writes.
module led_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PERIOD_RST = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic [7:0]  level,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, BLANK} state_t;

  state_t      state, state_next;
  logic        run, mode, loop_en;
  logic [2:0]  last_idx;
  logic [23:0] period;
  logic [7:0]  pattern [DEPTH];
  logic [2:0]  index, index_next;
  logic [23:0] count, count_next;
  logic        done, done_next;
  logic        run_clear;
  logic [7:0]  last_value;
  logic        busy;

  logic        cfg_wr, ctrl_wr, period_wr, pattern_wr;
  logic [23:0] reload;
  logic [3:0]  level_n;
  logic [8:0]  bar_full;
  logic [7:0]  value;
  logic        unused_bits;

  assign cfg_wr     = s_chipselect && !s_write_n;
  assign ctrl_wr    = cfg_wr && (s_address == 4'h0);
  assign period_wr  = cfg_wr && (s_address == 4'h1);
  assign pattern_wr = cfg_wr && s_address[3];
  assign busy       = (state != IDLE);

  assign unused_bits = ^{s_writedata[31:24], bar_full[8]};

  // Periods below 2 clamp to 2, i.e. a reload value of 0.
  assign reload   = (period < 24'd2) ? 24'd0 : period - 24'd2;
  assign level_n  = (level == 8'd0) ? 4'd0 : {1'b0, level[7:5]} + 4'd1;
  assign bar_full = (9'd1 << level_n) - 9'd1;
  assign value    = mode ? bar_full[7:0] : pattern[index];

  always_comb begin
    state_next = state;
    index_next = index;
    count_next = count;
    done_next  = done;
    run_clear  = 1'b0;
    case (state)
      IDLE: ;
      STROBE: begin
        count_next = reload;
        state_next = WAIT;
      end
      WAIT: begin
        if (count != 24'd0) begin
          count_next = count - 24'd1;
        end else if (mode) begin
          if (bar_full[7:0] != last_value) state_next = STROBE;
          else                             count_next = reload;
        end else if (index < last_idx) begin
          index_next = index + 3'd1;
          state_next = STROBE;
        end else if (loop_en) begin
          index_next = '0;
          state_next = STROBE;
        end else begin
          done_next  = 1'b1;
          run_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      BLANK: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A CTRL write overrides whatever the sequence was about to do.
    if (ctrl_wr) begin
      done_next = 1'b0;
      run_clear = 1'b0;
      if (s_writedata[0]) begin
        index_next = '0;
        state_next = STROBE;
      end else if (state != IDLE) begin
        state_next = BLANK;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      index      <= '0;
      count      <= '0;
      done       <= 1'b0;
      last_value <= '0;
      run        <= 1'b0;
      mode       <= 1'b0;
      loop_en    <= 1'b0;
      last_idx   <= '0;
      period     <= 24'(PERIOD_RST);
      for (int unsigned i = 0; i < DEPTH; i++) pattern[i] <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
      count <= count_next;
      done  <= done_next;
      if (state == STROBE)     last_value <= value;
      else if (state == BLANK) last_value <= '0;
      if (ctrl_wr) begin
        run      <= s_writedata[0];
        mode     <= s_writedata[1];
        loop_en  <= s_writedata[2];
        last_idx <= s_writedata[6:4];
      end else if (run_clear) begin
        run <= 1'b0;
      end
      if (period_wr)  period <= s_writedata[23:0];
      if (pattern_wr) pattern[s_address[2:0]] <= s_writedata[7:0];
    end
  end

  always_comb begin
    s_readdata = '0;
    if (s_address[3]) begin
      s_readdata = {24'b0, pattern[s_address[2:0]]};
    end else begin
      case (s_address[2:0])
        3'd0:    s_readdata = {25'b0, last_idx, 1'b0, loop_en, mode, run};
        3'd1:    s_readdata = {8'b0, period};
        3'd2:    s_readdata = {25'b0, index, 2'b0, done, busy};
        default: s_readdata = '0;
      endcase
    end
  end

  assign m_address    = '0;
  assign m_chipselect = (state == STROBE) || (state == BLANK);
  assign m_write_n    = !m_chipselect;
  assign m_writedata  = {24'b0, (state == STROBE) ? value : 8'h00};

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer: table one-shot/loop,
// bargraph, stop, short periods and asynchronous reset.
module tb_led_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [7:0]  level;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nstrobes = 0;
  int wr_cyc;

  led_sequencer #(.DEPTH(8), .PERIOD_RST(5000000)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .level(level),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (m_chipselect && !m_write_n) nstrobes <= nstrobes + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write commits.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
    wr_cyc = cyc;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    s_address = a;
    #1;
    d = s_readdata;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  // Returns the cycle and value of the next strobe, leaving time one negedge later.
  task automatic wait_strobe(input string tag, output int at, output logic [7:0] val);
    int n = 0;
    while (!(m_chipselect && !m_write_n) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (m_chipselect && !m_write_n) else begin
      errors++;
      $error("FAIL %s: observed no strobe expected strobe within 60 cycles", tag);
    end
    at  = cyc;
    val = m_writedata[7:0];
    @(negedge clk);
  endtask

  initial begin
    int s0, s1, s2, n0;
    logic [7:0] v;

    reset_n = 1'b0; s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1;
    s_writedata = '0; level = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_cs", {31'b0, m_chipselect}, 32'd0);
    check("rst_wn", {31'b0, m_write_n}, 32'd1);
    check("rst_wdata", m_writedata, 32'd0);
    check("rst_addr", {30'b0, m_address}, 32'd0);
    rd_check("rst_ctrl", 4'h0, 32'h0);
    rd_check("rst_period", 4'h1, 32'd5000000);
    rd_check("rst_status", 4'h2, 32'h0);
    rd_check("rst_tab3", 4'hB, 32'h0);
    rd_check("unmapped", 4'h5, 32'h0);
    @(negedge clk);

    // Table one-shot, PERIOD 4
    wr(4'h1, 32'd4);
    wr(4'h8, 32'h01);
    wr(4'h9, 32'h02);
    wr(4'hA, 32'h04);
    rd_check("tab1_rd", 4'h9, 32'h02);
    wr(4'h0, 32'h21);
    wait_strobe("os_s0", s0, v);
    check("os_v0", {24'b0, v}, 32'h01);
    check("os_lat", s0, wr_cyc);
    wait_strobe("os_s1", s1, v);
    check("os_v1", {24'b0, v}, 32'h02);
    check("os_sp1", s1 - s0, 32'd4);
    wait_strobe("os_s2", s2, v);
    check("os_v2", {24'b0, v}, 32'h04);
    check("os_sp2", s2 - s1, 32'd4);
    repeat (2) @(negedge clk);
    rd_check("os_busy_pre", 4'h2, 32'h21);
    @(negedge clk);
    rd_check("os_done", 4'h2, 32'h22);
    rd_check("os_ctrl", 4'h0, 32'h20);
    n0 = nstrobes;
    repeat (20) @(negedge clk);
    check("os_quiet", nstrobes, n0);

    // Table loop, then stop mid-WAIT
    wr(4'h0, 32'h25);
    rd_check("lp_done_clr", 4'h2, 32'h01);
    wait_strobe("lp_s0", s0, v);
    check("lp_v0", {24'b0, v}, 32'h01);
    wait_strobe("lp_s1", s1, v);
    check("lp_v1", {24'b0, v}, 32'h02);
    wait_strobe("lp_s2", s2, v);
    check("lp_v2", {24'b0, v}, 32'h04);
    wait_strobe("lp_s3", s0, v);
    check("lp_v3", {24'b0, v}, 32'h01);
    check("lp_sp3", s0 - s2, 32'd4);
    rd_check("lp_idx0", 4'h2, 32'h01);
    wait_strobe("lp_s4", s1, v);
    check("lp_v4", {24'b0, v}, 32'h02);
    rd_check("lp_idx1", 4'h2, 32'h11);
    wr(4'h0, 32'h00);
    check("blk_cs", {30'b0, m_chipselect, m_write_n}, 32'h2);
    check("blk_data", m_writedata, 32'h0);
    @(negedge clk);
    check("blk_after_cs", {31'b0, m_chipselect}, 32'd0);
    rd_check("blk_status", 4'h2, 32'h10);

    // Short periods clamp to 2
    wr(4'h1, 32'd1);
    wr(4'h0, 32'h21);
    wait_strobe("p1_s0", s0, v);
    wait_strobe("p1_s1", s1, v);
    check("p1_sp1", s1 - s0, 32'd2);
    wait_strobe("p1_s2", s2, v);
    check("p1_sp2", s2 - s1, 32'd2);
    check("p1_v2", {24'b0, v}, 32'h04);
    @(negedge clk);
    rd_check("p1_done", 4'h2, 32'h22);
    wr(4'h1, 32'd0);
    wr(4'h0, 32'h21);
    wait_strobe("p0_s0", s0, v);
    wait_strobe("p0_s1", s1, v);
    check("p0_sp1", s1 - s0, 32'd2);

    // Bargraph, PERIOD 3
    repeat (6) @(negedge clk);
    wr(4'h1, 32'd3);
    level = 8'h00;
    wr(4'h0, 32'h03);
    wait_strobe("bg_s0", s0, v);
    check("bg_v0", {24'b0, v}, 32'h00);
    n0 = nstrobes;
    repeat (8) @(negedge clk);
    check("bg_zero_quiet", nstrobes, n0);
    level = 8'h40;
    wait_strobe("bg_s40", s0, v);
    check("bg_v40", {24'b0, v}, 32'h07);
    n0 = nstrobes;
    repeat (10) @(negedge clk);
    check("bg_40_quiet", nstrobes, n0);
    rd_check("bg_busy", 4'h2, 32'h01);
    level = 8'hFF;
    wait_strobe("bg_sff", s0, v);
    check("bg_vff", {24'b0, v}, 32'hFF);
    level = 8'h01;
    wait_strobe("bg_s01", s0, v);
    check("bg_v01", {24'b0, v}, 32'h01);
    wr(4'h0, 32'h00);
    check("bg_blk", m_writedata, 32'h0);
    check("bg_blk_cs", {31'b0, m_chipselect}, 32'd1);

    // Asynchronous reset mid-WAIT
    @(negedge clk);
    wr(4'h1, 32'd10);
    wr(4'h0, 32'h25);
    wait_strobe("ar_s0", s0, v);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("ar_cs", {31'b0, m_chipselect}, 32'd0);
    check("ar_wn", {31'b0, m_write_n}, 32'd1);
    rd_check("ar_status", 4'h2, 32'h0);
    rd_check("ar_ctrl", 4'h0, 32'h0);
    rd_check("ar_period", 4'h1, 32'd5000000);
    rd_check("ar_tab0", 4'h8, 32'h0);
    n0 = nstrobes;
    repeat (4) @(negedge clk);
    check("ar_quiet", nstrobes, n0);
    reset_n = 1'b1;
    @(negedge clk);
    wr(4'h8, 32'h5A);
    wr(4'h1, 32'd4);
    wr(4'h0, 32'h01);
    wait_strobe("ar_run", s0, v);
    check("ar_v", {24'b0, v}, 32'h5A);
    check("ar_lat", s0, wr_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
